// File: rtl/dot_dispatch.sv
// Tile scheduler for the iterative dot-product engine: loads an A/B tile from a byte stream,
// issues every (row, col) pair to the engine, captures each result and streams the result tile out.
module dot_dispatch #(
  parameter int N       = 32,
  parameter int R       = 2,
  parameter int C       = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  input  logic [7:0]          s_data,
  output logic                s_ready,
  output logic [N-1:0][7:0]   dp_row,
  output logic [N-1:0][7:0]   dp_col,
  output logic                dp_valid,
  input  logic                dp_res_valid,
  input  logic [7:0]          dp_res,
  output logic                m_valid,
  output logic [7:0]          m_data,
  output logic                m_last,
  input  logic                m_ready,
  output logic                busy,
  output logic                err
);

  localparam int V  = R + C;
  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam int VW = (V > 1) ? $clog2(V) : 1;
  localparam int IW = (R > 1) ? $clog2(R) : 1;
  localparam int JW = (C > 1) ? $clog2(C) : 1;
  localparam int RW = (R * C > 1) ? $clog2(R * C) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {LOAD, ISSUE, WAIT, DRAIN} state_t;

  state_t          state;
  logic [NW-1:0]   elem_cnt;
  logic [VW-1:0]   vec_cnt;
  logic [IW-1:0]   i_idx;
  logic [JW-1:0]   j_idx;
  logic [RW-1:0]   out_idx;
  logic [TW-1:0]   tmo_cnt;

  logic [N-1:0][7:0] a_tile [R];
  logic [N-1:0][7:0] b_tile [C];
  logic [7:0]        res_buf [R*C];

  logic          load_en;
  logic          load_last;
  logic          capture;
  logic          last_pair;
  logic          pair_active;
  logic [RW-1:0] res_idx;

  assign load_en     = (state == LOAD) && s_valid;
  assign load_last   = load_en && (elem_cnt == NW'(N - 1)) && (vec_cnt == VW'(V - 1));
  // A missing result after TIMEOUT wait cycles still advances the schedule.
  assign capture     = (state == WAIT) && (dp_res_valid || (tmo_cnt == TW'(TIMEOUT - 1)));
  assign last_pair   = (i_idx == IW'(R - 1)) && (j_idx == JW'(C - 1));
  assign res_idx     = RW'(i_idx) * RW'(C) + RW'(j_idx);
  assign pair_active = (state == ISSUE) || (state == WAIT);

  // Tile and result storage carry no reset; their contents are rewritten before use.
  always_ff @(posedge clk) begin
    if (load_en) begin
      for (int k = 0; k < R; k++)
        if (vec_cnt == VW'(k)) a_tile[k][elem_cnt] <= s_data;
      for (int k = 0; k < C; k++)
        if (vec_cnt == VW'(R + k)) b_tile[k][elem_cnt] <= s_data;
    end
    if (capture)
      res_buf[res_idx] <= dp_res_valid ? dp_res : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LOAD;
      elem_cnt <= '0;
      vec_cnt  <= '0;
      i_idx    <= '0;
      j_idx    <= '0;
      out_idx  <= '0;
      tmo_cnt  <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (load_en) begin
            if (elem_cnt == NW'(N - 1)) begin
              elem_cnt <= '0;
              vec_cnt  <= vec_cnt + VW'(1);
            end else begin
              elem_cnt <= elem_cnt + NW'(1);
            end
            if (load_last) begin
              vec_cnt <= '0;
              i_idx   <= '0;
              j_idx   <= '0;
              state   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          tmo_cnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (capture) begin
            if (!dp_res_valid) err <= 1'b1;
            if (j_idx == JW'(C - 1)) begin
              j_idx <= '0;
              i_idx <= i_idx + IW'(1);
            end else begin
              j_idx <= j_idx + JW'(1);
            end
            if (last_pair) begin
              out_idx <= '0;
              state   <= DRAIN;
            end else begin
              state <= ISSUE;
            end
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        DRAIN: begin
          if (m_ready) begin
            if (out_idx == RW'(R * C - 1)) begin
              elem_cnt <= '0;
              vec_cnt  <= '0;
              state    <= LOAD;
            end else begin
              out_idx <= out_idx + RW'(1);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Outputs decode registered state; operands stay put from issue until capture.
  assign s_ready  = (state == LOAD);
  assign busy     = !((state == LOAD) && (elem_cnt == '0) && (vec_cnt == '0));
  assign dp_valid = (state == ISSUE);
  assign dp_row   = pair_active ? a_tile[i_idx] : '0;
  assign dp_col   = pair_active ? b_tile[j_idx] : '0;
  assign m_valid  = (state == DRAIN);
  assign m_data   = m_valid ? res_buf[out_idx] : 8'h00;
  assign m_last   = m_valid && (out_idx == RW'(R * C - 1));

endmodule

// File: tb/tb_dot_dispatch.sv
// Directed bench for dot_dispatch with a behavioural 34-cycle engine model (switchable to a
// silent stub) and a separate injector for stray result pulses.
module tb_dot_dispatch;
  localparam int N = 32, R = 2, C = 2, TIMEOUT = 64, ENG_LAT = 34;
  localparam int NB = (R + C) * N;

  logic              clk, rst, s_valid, s_ready, dp_valid, dp_res_valid;
  logic [7:0]        s_data, dp_res, m_data;
  logic [N-1:0][7:0] dp_row, dp_col;
  logic              m_valid, m_last, m_ready, busy, err;

  dot_dispatch #(.N(N), .R(R), .C(C), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .dp_row(dp_row), .dp_col(dp_col), .dp_valid(dp_valid),
    .dp_res_valid(dp_res_valid), .dp_res(dp_res),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine model: result pulse ENG_LAT cycles after the issue cycle; not reset by rst.
  logic       eng_stub = 1'b0, eng_v = 1'b0, inj_v = 1'b0;
  logic [7:0] eng_sum = 8'h00, eng_d = 8'h00;
  int         eng_cnt = 0;

  assign dp_res_valid = eng_v | inj_v;
  assign dp_res       = inj_v ? 8'hAA : eng_d;

  function automatic logic [7:0] dot8(input logic [N-1:0][7:0] a, input logic [N-1:0][7:0] b);
    logic [7:0]  s;
    logic [15:0] p;
    s = 8'h00;
    for (int k = 0; k < N; k++) begin
      p = 16'(a[k]) * 16'(b[k]);
      s = s + p[7:0];
    end
    return s;
  endfunction

  always @(posedge clk) begin
    eng_v <= 1'b0;
    if (dp_valid) begin
      eng_sum <= dot8(dp_row, dp_col);
      eng_cnt <= ENG_LAT - 1;
    end else if (eng_cnt > 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1 && !eng_stub) begin
        eng_v <= 1'b1;
        eng_d <= eng_sum;
      end
    end
  end

  int         cmp_n = 0, mis_n = 0;
  logic [7:0] tile [NB];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_n++;
    assert (obs === exp) else begin
      mis_n++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_uniform(input logic [7:0] a0, input logic [7:0] a1,
                             input logic [7:0] b0, input logic [7:0] b1);
    for (int k = 0; k < N; k++) begin
      tile[k] = a0; tile[N + k] = a1; tile[2*N + k] = b0; tile[3*N + k] = b1;
    end
  endtask

  task automatic send(input int start, input int count, input int idle_pct);
    for (int n = start; n < start + count; n++) begin
      while (idle_pct > 0 && $urandom_range(99) < idle_pct) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_data  = tile[n];
      chk("s_ready_load", s_ready, 1);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drain(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                       input logic [7:0] e3, input int stall_pct);
    logic [7:0] expv [4];
    logic [7:0] held;
    logic       stalled;
    int         got, cyc, first_cyc, last_cyc;
    expv = '{e0, e1, e2, e3};
    got = 0; cyc = 0; first_cyc = 0; last_cyc = 0; stalled = 1'b0; held = 8'h00;
    while (got < 4 && cyc < 2000) begin
      m_ready = (stall_pct == 0) || ($urandom_range(99) >= stall_pct);
      if (stalled) chk("m_data_hold", m_data, held);
      stalled = 1'b0;
      if (m_valid) begin
        if (m_ready) begin
          chk($sformatf("res%0d", got), m_data, expv[got]);
          chk($sformatf("m_last%0d", got), m_last, (got == 3));
          if (got == 0) first_cyc = cyc;
          last_cyc = cyc;
          got++;
        end else begin
          stalled = 1'b1;
          held    = m_data;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    m_ready = 1'b0;
    chk("drain_count", got, 4);
    if (stall_pct == 0) chk("no_bubble", last_cyc - first_cyc, 3);
    chk("post_drain_m_valid", m_valid, 0);
    chk("post_drain_busy", busy, 0);
    chk("post_drain_s_ready", s_ready, 1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, gap, seen;
    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", s_ready, 1);
    chk("rst_dp_valid", dp_valid, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_dp_row_zero", (dp_row == '0), 1);
    chk("rst_dp_col_zero", (dp_col == '0), 1);
    rst = 1'b0;

    // All ones: four results of 32, plus minimum latency from last byte to first result.
    set_uniform(8'd1, 8'd1, 8'd1, 8'd1);
    send(0, 1, 0);
    chk("busy_after_first_byte", busy, 1);
    send(1, NB - 1, 0);
    lat = 1;
    while (!m_valid && lat < 1000) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, 4 * (1 + ENG_LAT) + 1);
    drain(8'h20, 8'h20, 8'h20, 8'h20, 0);
    chk("err_clean", err, 0);

    // A row0 = B col0 = 1..32, everything else zero: sum of squares 11440 mod 256.
    set_uniform(8'd0, 8'd0, 8'd0, 8'd0);
    for (int k = 0; k < N; k++) begin
      tile[k]       = 8'(k + 1);
      tile[2*N + k] = 8'(k + 1);
    end
    send(0, NB, 0);
    drain(8'hB0, 8'h00, 8'h00, 8'h00, 0);

    // Distinct per-pair results with input and output stalls.
    set_uniform(8'd1, 8'd2, 8'd1, 8'd3);
    send(0, NB, 50);
    chk("issue_after_load", dp_valid, 1);
    chk("issue_row_elem", dp_row[7], 1);
    chk("issue_col_elem", dp_col[7], 1);
    @(posedge clk); #1;
    chk("issue_one_cycle", dp_valid, 0);
    chk("row_held_in_wait", dp_row[7], 1);
    drain(8'h20, 8'h60, 8'h40, 8'hC0, 30);

    // Reset after 50 load bytes, then a clean full reload.
    send(0, 50, 0);
    pulse_rst();
    chk("midload_rst_busy", busy, 0);
    chk("midload_rst_s_ready", s_ready, 1);
    send(0, NB, 0);
    drain(8'h20, 8'h60, 8'h40, 8'hC0, 0);

    // Reset during WAIT: no further issues, the late engine result is ignored.
    send(0, NB, 0);
    repeat (6) begin
      @(posedge clk); #1;
    end
    pulse_rst();
    chk("wait_rst_busy", busy, 0);
    chk("wait_rst_s_ready", s_ready, 1);
    chk("wait_rst_dp_valid", dp_valid, 0);
    seen = 0;
    repeat (60) begin
      if (dp_valid || m_valid) seen++;
      @(posedge clk); #1;
    end
    chk("wait_rst_quiet", seen, 0);
    chk("wait_rst_idle_busy", busy, 0);
    send(0, NB, 0);
    drain(8'h20, 8'h60, 8'h40, 8'hC0, 0);
    chk("wait_rst_err", err, 0);

    // Silent engine: every pair times out, results are zero, err latches.
    eng_stub = 1'b1;
    send(0, NB, 0);
    chk("stub_first_issue", dp_valid, 1);
    gap = 0;
    do begin
      @(posedge clk); #1;
      gap++;
    end while (!dp_valid && gap < 200);
    chk("timeout_gap", gap, TIMEOUT + 1);
    chk("err_after_timeout", err, 1);
    drain(8'h00, 8'h00, 8'h00, 8'h00, 0);
    chk("err_after_stub_tile", err, 1);

    // Stray result pulse while idle in LOAD, then a good tile; err stays set until rst.
    eng_stub = 1'b0;
    inj_v = 1'b1;
    @(posedge clk); #1;
    inj_v = 1'b0;
    chk("stray_pulse_busy", busy, 0);
    chk("stray_pulse_s_ready", s_ready, 1);
    send(0, NB, 0);
    drain(8'h20, 8'h60, 8'h40, 8'hC0, 0);
    chk("err_sticky", err, 1);
    pulse_rst();
    chk("err_cleared_by_rst", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, mis_n);
    $finish;
  end
endmodule
